gen_elastic_pipe: RTL



---
 rtl/gen_elastic_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gen_elastic_pipe.sv
`timescale 1ns/1ps
// Purpose : DEPTH-stage skid-buffered elastic register; each stage holds up to two beats.
// Latency : DEPTH cycles from in_valid presented to out_valid on an empty, unstalled pipe.
// Backpr. : in_ready is a flop output (!skid valid); all 2*DEPTH registers fill before it drops.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of every held beat (highest priority)
//   def_val               data register load value on reset/flush; out_data while idle
//   in_valid/ready/data   upstream handshake
//   out_valid/ready/data  downstream handshake
//   count                 number of beats held (0..2*DEPTH)
module gen_elastic_pipe #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 1,
    localparam int CW    = $clog2(2*DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] vld_m;
    logic [DEPTH-1:0] vld_s;
    logic [DW-1:0]    dat_m  [DEPTH];
    logic [DEPTH-1:0] up_vld;
    logic [DW-1:0]    up_dat [DEPTH];
    logic [DEPTH-1:0] dn_rdy;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            logic          vm;
            logic          vs;
            logic [DW-1:0] dm;
            logic [DW-1:0] ds;
            logic          free;
            logic          xin;

            if (i == 0) begin : g_first
                assign up_vld[i] = in_valid;
                assign up_dat[i] = in_data;
            end else begin : g_chain
                assign up_vld[i] = vld_m[i-1];
                assign up_dat[i] = dat_m[i-1];
            end

            if (i == DEPTH-1) begin : g_last
                assign dn_rdy[i] = out_ready;
            end else begin : g_inner
                // Ready of the next stage is its registered "skid empty" flag.
                assign dn_rdy[i] = ~vld_s[i+1];
            end

            // Main slot can accept new content: it is empty or being taken this edge.
            assign free = ~vm | dn_rdy[i];
            // Incoming transfer; ready is !vs, so no beat arrives while the skid is full.
            assign xin  = up_vld[i] & ~vs;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vm <= 1'b0;
                    vs <= 1'b0;
                    dm <= def_val;
                    ds <= def_val;
                end else if (flush) begin
                    vm <= 1'b0;
                    vs <= 1'b0;
                    dm <= def_val;
                    ds <= def_val;
                end else if (free) begin
                    if (vs) begin
                        // Skid is older than anything incoming; it must go first.
                        vm <= 1'b1;
                        dm <= ds;
                        vs <= 1'b0;
                    end else begin
                        vm <= xin;
                        if (xin) begin
                            dm <= up_dat[i];
                        end
                    end
                end else if (xin) begin
                    vs <= 1'b1;
                    ds <= up_dat[i];
                end
            end

            assign vld_m[i] = vm;
            assign vld_s[i] = vs;
            assign dat_m[i] = dm;
        end
    endgenerate

    assign in_ready  = ~vld_s[0];
    assign out_valid = vld_m[DEPTH-1];
    assign out_data  = out_valid ? dat_m[DEPTH-1] : def_val;

    logic in_xfer;
    logic out_xfer;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule
